// File: rtl/udp_filter_pkg.sv
// Shared definitions for the udp_filter sequencer and the filter itself.
//   fsm_t           sequencer state encoding
//   ETHERTYPE etc.  header match constants shared with udp_filter
//   MIN_BEATS_DEF   beats the filter needs to reach its final state
package udp_filter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RECV      = 3'd1,
      ST_DRAIN     = 3'd2,
      ST_WAIT_IDLE = 3'd3,
      ST_ABORT     = 3'd4,
      ST_DISCARD   = 3'd5
   } fsm_t;

   localparam logic [15:0] ETHERTYPE     = 16'h0800;
   localparam logic [3:0]  VERSION       = 4'h4;
   localparam logic [7:0]  PROTOCOL      = 8'h11;
   localparam int          MIN_BEATS_DEF = 6;

endpackage

// File: rtl/udp_filter_ctrl_if.sv
// AXI-Stream beat bundle used for both the input and output sides.
//   tdata/tvalid/tlast  driven by the master
//   tready              driven by the slave
interface udp_filter_ctrl_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udp_filter_stats.sv
// Frame statistics: three free-running counters that wrap at 2^CNT_WIDTH.
//   ok_inc_i / drop_inc_i / err_inc_i   one-cycle increment strobes
//   frames_ok_o / frames_drop_o / frames_err_o   counter values
module udp_filter_stats #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 a_rst_n_i,
   input  logic                 ok_inc_i,
   input  logic                 drop_inc_i,
   input  logic                 err_inc_i,
   output logic [CNT_WIDTH-1:0] frames_ok_o,
   output logic [CNT_WIDTH-1:0] frames_drop_o,
   output logic [CNT_WIDTH-1:0] frames_err_o
);

   localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] ok_q, drop_q, err_q;

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         ok_q   <= '0;
         drop_q <= '0;
         err_q  <= '0;
      end else begin
         if (ok_inc_i)   ok_q   <= ok_q + ONE_C;
         if (drop_inc_i) drop_q <= drop_q + ONE_C;
         if (err_inc_i)  err_q  <= err_q + ONE_C;
      end
   end

   assign frames_ok_o   = ok_q;
   assign frames_drop_o = drop_q;
   assign frames_err_o  = err_q;

endmodule

// File: rtl/udp_filter_ctrl.sv
// Sequencer around one udp_filter and its FWFT packet FIFO.
//   s_axis            input stream, gated into the filter
//   flt_*             filter control and status taps
//   fifo_*            packet FIFO pop/reset and head word
//   m_axis            replay of accepted frames with regenerated tlast
//   frames_*_o        forwarded / dropped / runt+oversize counts
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | tready low, waits for en_i
// RECV       | accepts beats into the filter, tracks beats/writes/verdict
// DRAIN      | replays the stored frame from the FIFO onto m_axis
// WAIT_IDLE  | waits for FIFO empty and filter quiet
// ABORT      | one-cycle reset of filter and FIFO after runt/oversize
// DISCARD    | swallows the rest of an oversize frame up to tlast
module udp_filter_ctrl
   import udp_filter_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 256,
   parameter int MIN_BEATS  = MIN_BEATS_DEF,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  a_rst_n_i,
   input  logic                  en_i,
   udp_filter_ctrl_if.slave      s_axis,
   output logic                  flt_s_rst_n_o,
   output logic                  flt_en_o,
   output logic [DATA_WIDTH-1:0] flt_frame_o,
   output logic                  flt_last_o,
   input  logic                  flt_frame_valid_i,
   input  logic                  flt_fifo_wr_en_i,
   input  logic                  flt_fifo_rst_n_i,
   output logic                  fifo_rst_n_o,
   output logic                  fifo_rd_en_o,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   input  logic                  fifo_empty_i,
   udp_filter_ctrl_if.master     m_axis,
   output logic [CNT_WIDTH-1:0]  frames_ok_o,
   output logic [CNT_WIDTH-1:0]  frames_drop_o,
   output logic [CNT_WIDTH-1:0]  frames_err_o
);

   localparam int WW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(FIFO_DEPTH) + 2;

   localparam logic [WW-1:0] ONE_W   = WW'(1);
   localparam logic [WW-1:0] DEPTH_W = WW'(FIFO_DEPTH);
   localparam logic [BW-1:0] ONE_B   = BW'(1);
   // beat_cnt + 1 < MIN_BEATS, rearranged so a saturated counter cannot wrap
   localparam logic [BW-1:0] RUNT_B  = BW'(MIN_BEATS - 1);

   fsm_t          state_q, state_d;
   logic          s_ready_q;
   logic          abort_rst_n_q;
   logic          runt_q, runt_d;
   logic          drop_q;
   logic [BW-1:0] beat_cnt_q;
   logic [WW-1:0] wr_cnt_q;
   logic [WW-1:0] rd_cnt_q;

   logic          s_acc, acc_last;
   logic [WW-1:0] wr_next;
   logic          in_drain, m_valid, m_last, pop;
   logic          ok_inc, drop_inc, err_inc;

   assign s_acc    = s_axis.tvalid & s_ready_q;
   assign acc_last = s_acc & s_axis.tlast;
   assign wr_next  = wr_cnt_q + WW'(flt_fifo_wr_en_i);

   assign in_drain = (state_q == ST_DRAIN);
   assign m_valid  = in_drain & ~fifo_empty_i;
   assign m_last   = in_drain & (rd_cnt_q == (wr_cnt_q - ONE_W));
   assign pop      = m_valid & m_axis.tready;

   always_comb begin
      state_d  = state_q;
      runt_d   = runt_q;
      ok_inc   = 1'b0;
      drop_inc = 1'b0;
      err_inc  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en_i) state_d = ST_RECV;
         end
         ST_RECV: begin
            if (acc_last) begin
               if (beat_cnt_q < RUNT_B) begin
                  state_d = ST_ABORT;
                  runt_d  = 1'b1;
               end else if (drop_q || !flt_fifo_rst_n_i) begin
                  drop_inc = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else if (flt_fifo_rst_n_i && (wr_next >= DEPTH_W)) begin
               state_d = ST_ABORT;
               runt_d  = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (pop && m_last) begin
               ok_inc  = 1'b1;
               state_d = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (fifo_empty_i && !flt_frame_valid_i) state_d = ST_IDLE;
         end
         ST_ABORT: begin
            err_inc = 1'b1;
            state_d = runt_q ? ST_IDLE : ST_DISCARD;
         end
         ST_DISCARD: begin
            if (acc_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         state_q       <= ST_IDLE;
         runt_q        <= 1'b0;
         s_ready_q     <= 1'b0;
         abort_rst_n_q <= 1'b1;
         drop_q        <= 1'b0;
         beat_cnt_q    <= '0;
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         runt_q        <= runt_d;
         s_ready_q     <= (state_d == ST_RECV) || (state_d == ST_DISCARD);
         abort_rst_n_q <= (state_d != ST_ABORT);
         case (state_q)
            ST_IDLE: begin
               beat_cnt_q <= '0;
               wr_cnt_q   <= '0;
               rd_cnt_q   <= '0;
               drop_q     <= 1'b0;
            end
            ST_RECV: begin
               if (s_acc && (beat_cnt_q != '1)) beat_cnt_q <= beat_cnt_q + ONE_B;
               // a drop verdict empties the FIFO, so occupancy restarts
               if (!flt_fifo_rst_n_i) begin
                  drop_q   <= 1'b1;
                  wr_cnt_q <= '0;
               end else begin
                  wr_cnt_q <= wr_next;
               end
            end
            ST_DRAIN: begin
               // late filter writes still belong to this frame
               wr_cnt_q <= wr_next;
               if (pop) rd_cnt_q <= rd_cnt_q + ONE_W;
            end
            default: ;
         endcase
      end
   end

   assign s_axis.tready = s_ready_q;
   assign flt_en_o      = s_acc & (state_q != ST_DISCARD);
   assign flt_frame_o   = s_axis.tdata;
   assign flt_last_o    = s_axis.tlast;
   assign flt_s_rst_n_o = abort_rst_n_q;
   assign fifo_rst_n_o  = flt_fifo_rst_n_i & abort_rst_n_q;
   assign fifo_rd_en_o  = pop;

   assign m_axis.tvalid = m_valid;
   assign m_axis.tdata  = in_drain ? fifo_data_i : '0;
   assign m_axis.tlast  = m_last;

   udp_filter_stats #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_stats (
      .clk_i         (clk_i),
      .a_rst_n_i     (a_rst_n_i),
      .ok_inc_i      (ok_inc),
      .drop_inc_i    (drop_inc),
      .err_inc_i     (err_inc),
      .frames_ok_o   (frames_ok_o),
      .frames_drop_o (frames_drop_o),
      .frames_err_o  (frames_err_o)
   );

endmodule
